// File: rtl/scan_config_loader_pkg.sv
// scan_config_loader_pkg: shared loader FSM encoding and default bitstream/chain geometry
package scan_config_loader_pkg;
  localparam int WORD_WIDTH_DEF = 8;
  localparam int CHAIN_LEN_DEF = 12;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FINISH} state_t;
endpackage

// File: rtl/scan_config_loader.sv
// scan_config_loader: streams bitstream words LSB first into a scan chain, stalling the chain between words
module scan_config_loader
  import scan_config_loader_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  scan_data,
  output logic                  scan_en,
  output logic                  busy,
  output logic                  done
);
  localparam int IW = WORD_WIDTH > 1 ? $clog2(WORD_WIDTH) : 1;
  state_t state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [WORD_WIDTH-1:0] buf_q, buf_n;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    buf_n = buf_q;
    case (state)
      IDLE: if (start && !abort) begin
        state_n = LOAD;
        cnt_n = '0;
      end
      LOAD: if (abort) state_n = IDLE;
      else if (word_valid) begin
        buf_n = word_in;
        idx_n = '0;
        state_n = SHIFT;
      end
      SHIFT: begin
        cnt_n = cnt + 1'b1;
        idx_n = idx + 1'b1;
        state_n = abort ? IDLE
                : cnt == CNT_WIDTH'(CHAIN_LEN - 1) ? FINISH
                : idx == IW'(WORD_WIDTH - 1) ? LOAD : SHIFT;
      end
      default: state_n = IDLE;
    endcase
  end
  // chain outputs are registered from next-state so they line up with SHIFT cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      buf_q <= '0;
      scan_en <= 1'b0;
      scan_data <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      buf_q <= buf_n;
      scan_en <= state_n == SHIFT;
      scan_data <= state_n == SHIFT && buf_n[idx_n];
    end
  end
  assign word_ready = state == LOAD;
  assign busy = state == LOAD || state == SHIFT;
  assign done = state == FINISH;
endmodule

// File: tb/tb_scan_config_loader.sv
// tb_scan_config_loader: scoreboard bench driving 12-bit and 16-bit chains from the loader
module tb_scan_config_loader;
  logic clk = 0, rst = 0, start = 0, start16 = 0, abort = 0, word_valid = 0;
  logic [7:0] word_in = 0;
  logic word_ready, scan_data, scan_en, busy, done;
  logic word_ready16, scan_data16, scan_en16, busy16, done16;
  logic [11:0] chain = 0;
  logic [15:0] chain16 = 0;
  logic sel16 = 0;
  bit exp_q[$];
  int total = 0, passed = 0;
  int n_done = 0, n_done16 = 0, n_acc = 0, n_acc16 = 0, n_sh = 0, n_sh16 = 0;

  scan_config_loader #(.WORD_WIDTH(8), .CHAIN_LEN(12), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .word_in(word_in),
    .word_valid(word_valid), .word_ready(word_ready), .scan_data(scan_data),
    .scan_en(scan_en), .busy(busy), .done(done));

  scan_config_loader #(.WORD_WIDTH(8), .CHAIN_LEN(16), .CNT_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .abort(abort), .word_in(word_in),
    .word_valid(word_valid), .word_ready(word_ready16), .scan_data(scan_data16),
    .scan_en(scan_en16), .busy(busy16), .done(done16));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (scan_en) chain <= {scan_data, chain[11:1]};
    if (scan_en16) chain16 <= {scan_data16, chain16[15:1]};
  end

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always begin
    @(negedge clk);
    #2;
    if (scan_en) begin
      n_sh++;
      if (exp_q.size() == 0) chk("unexpected_shift", 1, 0);
      else chk("scan_bit", scan_data, exp_q.pop_front());
    end else chk("scan_data_gated", scan_data, 0);
    if (scan_en16) begin
      n_sh16++;
      if (exp_q.size() == 0) chk("unexpected_shift16", 1, 0);
      else chk("scan_bit16", scan_data16, exp_q.pop_front());
    end
    if (done) n_done++;
    if (done16) n_done16++;
    if (word_ready && word_valid && !abort) n_acc++;
    if (word_ready16 && word_valid && !abort) n_acc16++;
  end

  function automatic void push_bits(logic [15:0] v, int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
  endfunction

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    if (sel16) start16 = 1; else start = 1;
    @(negedge clk);
    start = 0;
    start16 = 0;
  endtask

  task automatic send_word(logic [7:0] w, int gap);
    int k;
    if (gap > 0) word_valid = 0;
    else begin
      word_in = w;
      word_valid = 1;
    end
    for (k = 0; k < 60; k++) begin
      if (sel16 ? word_ready16 : word_ready) break;
      @(negedge clk);
    end
    if (k == 60) chk("handshake_timeout", 0, 1);
    if (gap > 0) begin
      repeat (gap) begin
        chk("gap_scan_en", scan_en, 0);
        @(negedge clk);
      end
      word_in = w;
      word_valid = 1;
    end
    @(negedge clk);
  endtask

  task automatic wait_done(string name);
    int k;
    for (k = 0; k < 100; k++) begin
      if (sel16 ? done16 : done) break;
      @(negedge clk);
    end
    chk(name, k < 100, 1);
    @(negedge clk);
  endtask

  task automatic wait_shifts(int n);
    int c = 0;
    for (int k = 0; k < 60; k++) begin
      if (scan_en) c++;
      if (c >= n) break;
      @(negedge clk);
    end
    chk("shift_count_reached", c, n);
  endtask

  task automatic full_load(logic [7:0] w0, logic [7:0] w1, int gap, bit mid_start, string name, logic [11:0] img);
    int acc0 = n_acc, sh0 = n_sh, d0 = n_done;
    push_bits({w1, w0}, 12);
    pulse_start();
    send_word(w0, 0);
    if (mid_start) begin
      start = 1;
      @(negedge clk);
      start = 0;
    end
    send_word(w1, gap);
    word_valid = 0;
    wait_done({name, "_done"});
    cyc(2);
    chk({name, "_image"}, chain, img);
    chk({name, "_words"}, n_acc - acc0, 2);
    chk({name, "_shifts"}, n_sh - sh0, 12);
    chk({name, "_done_pulses"}, n_done - d0, 1);
    chk({name, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int acc0, sh0, d0;
    #1 rst = 1;
    #1 chk("reset_outputs", {scan_en, scan_data, word_ready, busy, done}, 0);
    cyc(2);
    rst = 0;
    cyc(1);
    chk("idle_outputs", {scan_en, scan_data, word_ready, busy, done}, 0);

    full_load(8'hA5, 8'h3C, 0, 0, "basic", 12'hCA5);
    full_load(8'hA5, 8'h3C, 5, 0, "gap", 12'hCA5);

    acc0 = n_acc;
    d0 = n_done;
    push_bits(16'h0096, 6);
    pulse_start();
    send_word(8'h96, 0);
    word_valid = 0;
    wait_shifts(6);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_scan_en", scan_en, 0);
    chk("abort_busy", busy, 0);
    cyc(3);
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_words", n_acc - acc0, 1);
    chk("abort_partial_image", chain, 12'h5B2);
    chk("abort_queue_empty", exp_q.size(), 0);

    full_load(8'h0F, 8'h09, 0, 0, "after_abort", 12'h90F);

    sh0 = n_sh;
    d0 = n_done;
    pulse_start();
    chk("load_ready", word_ready, 1);
    word_in = 8'hFF;
    word_valid = 1;
    abort = 1;
    @(negedge clk);
    abort = 0;
    word_valid = 0;
    chk("abort_load_busy", busy, 0);
    cyc(3);
    chk("abort_load_no_shift", n_sh - sh0, 0);
    chk("abort_load_no_done", n_done - d0, 0);
    chk("abort_load_image", chain, 12'h90F);

    full_load(8'hA5, 8'h3C, 0, 1, "start_in_shift", 12'hCA5);

    acc0 = n_acc;
    start = 1;
    abort = 1;
    @(negedge clk);
    start = 0;
    abort = 0;
    word_in = 8'h77;
    word_valid = 1;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_ready", word_ready, 0);
    cyc(3);
    word_valid = 0;
    chk("start_abort_words", n_acc - acc0, 0);

    push_bits(16'h0033, 3);
    pulse_start();
    send_word(8'h33, 0);
    word_valid = 0;
    wait_shifts(3);
    @(posedge clk);
    #2 rst = 1;
    #1 chk("rst_mid_shift_outputs", {scan_en, scan_data, word_ready, busy, done}, 0);
    @(negedge clk);
    rst = 0;
    chk("rst_queue_empty", exp_q.size(), 0);
    full_load(8'h5A, 8'hC3, 0, 0, "after_rst", 12'h35A);

    sel16 = 1;
    acc0 = n_acc16;
    sh0 = n_sh16;
    d0 = n_done16;
    push_bits(16'h3CA5, 16);
    pulse_start();
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    word_valid = 0;
    for (int k = 0; k < 40; k++) begin
      if (!scan_en16) break;
      @(negedge clk);
    end
    chk("c16_done_no_bubble", done16, 1);
    cyc(2);
    chk("c16_image", chain16, 16'h3CA5);
    chk("c16_words", n_acc16 - acc0, 2);
    chk("c16_shifts", n_sh16 - sh0, 16);
    chk("c16_done_pulses", n_done16 - d0, 1);
    chk("c16_busy_after", busy16, 0);
    chk("c16_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/scan_config_loader.md
SCAN_CONFIG_LOADER -- requirements
Module: scan_config_loader

Interface
REQ-001 Parameter WORD_WIDTH, default 8: bitstream word width in bits.
REQ-002 Parameter CHAIN_LEN, default 12: scan-chain length in bits (12 = 3-bit select x 4 outputs of one complete-connection block).
REQ-003 Parameter CNT_WIDTH, default 16: bit-counter width; SHALL satisfy 2**CNT_WIDTH > CHAIN_LEN.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a configuration load.
REQ-007 abort  input  1  cancels a load in progress.
REQ-008 word_in  input  WORD_WIDTH  bitstream word.
REQ-009 word_valid  input  1  word_in is valid.
REQ-010 word_ready  output  1  loader accepts a word this cycle.
REQ-011 scan_data  output  1  serial bit, drives the chain's scan_in.
REQ-012 scan_en  output  1  chain shift enable, drives the chain's scan_en.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  one-cycle pulse when exactly CHAIN_LEN bits have been shifted.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, SHIFT and FINISH.
REQ-016 IDLE: start=1 -> LOAD and clear the bit counter; otherwise stay in IDLE.
REQ-017 LOAD: word_ready=1; word_valid=1 (handshake) -> capture word_in into a shift buffer, clear the in-word index, go to SHIFT.
REQ-018 word_ready SHALL be 1 only in LOAD and SHALL not depend combinationally on word_valid.
REQ-019 SHIFT: each cycle scan_en=1 and scan_data = buffer bit at the in-word index, LSB first; the bit counter and in-word index each increment by 1.
REQ-020 In SHIFT, the last bit of the chain (counter = CHAIN_LEN-1) -> FINISH, and the remaining word bits SHALL be discarded.
REQ-021 Otherwise, in SHIFT, the last word bit (index = WORD_WIDTH-1) -> LOAD.
REQ-022 FINISH: done=1 for exactly one cycle, then -> IDLE.
REQ-023 scan_en SHALL be 0 in IDLE, LOAD and FINISH; the chain therefore holds during word gaps, with no bit lost or duplicated.
REQ-024 scan_data SHALL be 0 whenever scan_en=0.
REQ-025 busy SHALL be 1 in LOAD and SHIFT, and 0 in IDLE and FINISH.
REQ-026 Total words consumed per load SHALL be ceil(CHAIN_LEN/WORD_WIDTH).
REQ-027 abort=1 in LOAD or SHIFT -> IDLE next cycle: scan_en=0 that cycle, no done pulse, and the partial chain contents are left as-is.
REQ-028 abort takes priority over the handshake in the same cycle; the word SHALL be treated as not accepted.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 start and abort both asserted in IDLE -> SHALL remain in IDLE.
REQ-031 scan_data and scan_en SHALL be registered outputs, with no combinational path from any input.

Reset
REQ-032 rst=1 SHALL force IDLE, counter=0, index=0, buffer=0, and scan_en, scan_data, word_ready, busy, done all 0, independent of clk.
REQ-033 rst asserted mid-SHIFT SHALL stop shifting immediately; the first load after reset SHALL restart from bit 0.

Structure
REQ-034 The FSM state encoding and the default WORD_WIDTH/CHAIN_LEN constants SHALL live in the shared configuration package, for reuse by the chain and the top-level fabric.
REQ-035 The block SHALL be a single module with no sub-modules; the word buffer SHALL be indexed in place (no separate shift_reg instance), so that scan_en stays the only chain enable.

Verification (WORD_WIDTH=8, CHAIN_LEN=12, loader driving a 12-bit scan shift register)
REQ-036 start; words 0xA5, then 0x3C with valid held high -> scan_data sequence 1,0,1,0,0,1,0,1,0,0,1,1; exactly 12 scan_en cycles; done pulses once; chain holds 0xCA5 with bit 0 = first bit shifted, per chain orientation.
REQ-037 Second word presented 5 cycles late -> scan_en=0 during the gap and the chain contents are identical to REQ-036.
REQ-038 abort after 6 shifted bits -> scan_en=0 next cycle, busy=0, no done pulse; a subsequent full load yields the correct 12-bit image.
REQ-039 rst asserted mid-SHIFT -> all outputs 0 asynchronously; a new start reloads from bit 0.
REQ-040 start in SHIFT, and start with abort in IDLE -> no state change and no extra word consumed.
REQ-041 CHAIN_LEN=16 -> exactly 2 words consumed and 16 shifts, with no bubble between the last bit and done.
